// File: rtl/pi_controller_fx.sv
// Fixed-point PI controller: two-stage pipeline (multiply, then integrate/sum/clamp)
// with conditional-integration anti-windup and a synchronous integrator clear.
module pi_controller_fx #(
    parameter int DW      = 16,
    parameter int GW      = 16,
    parameter int FRAC    = 8,
    parameter int IW      = 32,
    parameter int OUT_MAX = 32767,
    parameter int OUT_MIN = -32768
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] error,
    input  logic signed [GW-1:0] kp,
    input  logic signed [GW-1:0] ki,
    input  logic                 int_clear,
    output logic                 out_valid,
    output logic signed [DW-1:0] out,
    output logic                 sat_hi,
    output logic                 sat_lo
);

    localparam int PW = DW + GW;
    localparam int TW = DW + GW - FRAC;
    localparam int SW = ((IW > TW) ? IW : TW) + 2;

    localparam logic signed [SW-1:0] MAX_S = SW'(OUT_MAX);
    localparam logic signed [SW-1:0] MIN_S = SW'(OUT_MIN);
    localparam logic signed [IW:0]   IMAX  = {2'b00, {(IW-1){1'b1}}};
    localparam logic signed [IW:0]   IMIN  = {2'b11, {(IW-1){1'b0}}};

    logic signed [PW-1:0] p_prod;
    logic signed [PW-1:0] i_prod;
    logic                 v1;
    logic signed [IW-1:0] integ;

    logic signed [PW-1:0] p_sh;
    logic signed [PW-1:0] i_sh;
    logic signed [IW-1:0] i_inc;
    logic signed [IW:0]   cand_w;
    logic signed [IW-1:0] cand;
    logic signed [SW-1:0] sum;
    logic                 hi;
    logic                 lo;
    logic                 hold;
    logic signed [DW-1:0] clamped;

    // A clear on the stage-2 edge forces the candidate integrator to zero,
    // so that sample's output is the proportional term alone.
    always_comb begin
        p_sh   = p_prod >>> FRAC;
        i_sh   = i_prod >>> FRAC;
        i_inc  = IW'(i_sh);
        cand_w = $signed({integ[IW-1], integ}) + $signed({i_inc[IW-1], i_inc});
        cand   = cand_w[IW-1:0];
        if (cand_w > IMAX) begin
            cand = IMAX[IW-1:0];
        end else if (cand_w < IMIN) begin
            cand = IMIN[IW-1:0];
        end
        if (int_clear) begin
            cand = '0;
        end
        sum     = SW'(p_sh) + SW'(cand);
        hi      = (sum > MAX_S);
        lo      = (sum < MIN_S);
        hold    = (hi && (i_inc > 0)) || (lo && (i_inc < 0));
        clamped = sum[DW-1:0];
        if (hi) begin
            clamped = MAX_S[DW-1:0];
        end else if (lo) begin
            clamped = MIN_S[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_prod    <= '0;
            i_prod    <= '0;
            v1        <= 1'b0;
            integ     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                p_prod <= PW'(error) * PW'(kp);
                i_prod <= PW'(error) * PW'(ki);
            end
            if (v1) begin
                out    <= clamped;
                sat_hi <= hi;
                sat_lo <= lo;
                if (!hold) begin
                    integ <= cand;
                end
            end
            // Clear has priority over any integrator update on the same edge.
            if (int_clear) begin
                integ <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pi_controller_fx.sv
// Directed bench for pi_controller_fx: each task drives a per-cycle table and
// compares the outputs seen just after every rising edge against hand values.
module tb_pi_controller_fx;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] error;
    logic signed [15:0] kp;
    logic signed [15:0] ki;
    logic               int_clear;
    logic               out_valid;
    logic signed [15:0] out;
    logic               sat_hi;
    logic               sat_lo;

    int assertions;
    int failures;

    pi_controller_fx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .error     (error),
        .kp        (kp),
        .ki        (ki),
        .int_clear (int_clear),
        .out_valid (out_valid),
        .out       (out),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one cycle of inputs, then wait until just after the next rising edge.
    task automatic apply_stimulus(input logic r, input logic v, input int e,
                                  input int kpv, input int kiv, input logic clr);
        rst       = r;
        in_valid  = v;
        error     = 16'(e);
        kp        = 16'(kpv);
        ki        = 16'(kiv);
        int_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) apply_stimulus(1'b1, 1'b1, 100, 256, 256, 1'b0);
            else       apply_stimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
            assertions += 4;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_ov c%0d: got %b expected 0", c, out_valid);
            end
            if (out !== 16'sd0) begin
                failures++;
                $display("[TB] FAIL reset_out c%0d: got %0d expected 0", c, out);
            end
            if (sat_hi !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_sat_hi c%0d: got %b expected 0", c, sat_hi);
            end
            if (sat_lo !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_sat_lo c%0d: got %b expected 0", c, sat_lo);
            end
        end
    endtask

    task automatic test_proportional();
        logic vin [8];
        int   err [8];
        int   kpv [8];
        logic eov [8];
        int   eout[8];
        vin  = '{1, 0, 0, 1, 0, 1, 0, 0};
        err  = '{100, 0, 0, -1, 0, 300, 0, 0};
        kpv  = '{256, 0, 0, 128, 0, -512, 0, 0};
        eov  = '{0, 1, 0, 0, 1, 0, 1, 0};
        eout = '{0, 100, 100, 100, -1, -1, -600, -600};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b0, vin[c], err[c], kpv[c], 0, 1'b0);
            assertions += 3;
            if (out_valid !== eov[c]) begin
                failures++;
                $display("[TB] FAIL prop_ov c%0d: got %b expected %b", c, out_valid, eov[c]);
            end
            if (out !== 16'(eout[c])) begin
                failures++;
                $display("[TB] FAIL prop_out c%0d: got %0d expected %0d", c, out, eout[c]);
            end
            if (sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
                failures++;
                $display("[TB] FAIL prop_sat c%0d: got %b%b expected 00", c, sat_hi, sat_lo);
            end
        end
    endtask

    task automatic test_integration();
        logic vin [10];
        logic eov [10];
        int   eout[10];
        vin  = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
        eov  = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0};
        eout = '{0, 5, 10, 15, 20, 20, 20, 20, 25, 25};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1'b0, vin[c], 10, 0, 128, 1'b0);
            assertions += 2;
            if (out_valid !== eov[c]) begin
                failures++;
                $display("[TB] FAIL integ_ov c%0d: got %b expected %b", c, out_valid, eov[c]);
            end
            if (out !== 16'(eout[c])) begin
                failures++;
                $display("[TB] FAIL integ_out c%0d: got %0d expected %0d", c, out, eout[c]);
            end
        end
    endtask

    task automatic test_anti_windup();
        logic vin [2][5];
        int   err [2][5];
        logic eov [2][5];
        int   eout[2][5];
        logic ehi [2][5];
        logic elo [2][5];
        vin  = '{'{1, 1, 1, 0, 0}, '{1, 1, 0, 1, 0}};
        err  = '{'{20000, 20000, -10000, 0, 0}, '{-20000, -20000, 0, 10000, 0}};
        eov  = '{'{0, 1, 1, 1, 0}, '{0, 1, 1, 0, 1}};
        eout = '{'{0, 20000, 32767, 10000, 10000}, '{0, -20000, -32768, -32768, -10000}};
        ehi  = '{'{0, 0, 1, 0, 0}, '{0, 0, 0, 0, 0}};
        elo  = '{'{0, 0, 0, 0, 0}, '{0, 0, 1, 1, 0}};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            for (int c = 0; c < 5; c++) begin
                apply_stimulus(1'b0, vin[t][c], err[t][c], 0, 256, 1'b0);
                assertions += 4;
                if (out_valid !== eov[t][c]) begin
                    failures++;
                    $display("[TB] FAIL aw_ov t%0d c%0d: got %b expected %b", t, c, out_valid, eov[t][c]);
                end
                if (out !== 16'(eout[t][c])) begin
                    failures++;
                    $display("[TB] FAIL aw_out t%0d c%0d: got %0d expected %0d", t, c, out, eout[t][c]);
                end
                if (sat_hi !== ehi[t][c]) begin
                    failures++;
                    $display("[TB] FAIL aw_sat_hi t%0d c%0d: got %b expected %b", t, c, sat_hi, ehi[t][c]);
                end
                if (sat_lo !== elo[t][c]) begin
                    failures++;
                    $display("[TB] FAIL aw_sat_lo t%0d c%0d: got %b expected %b", t, c, sat_lo, elo[t][c]);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic vin [8];
        int   err [8];
        int   kpv [8];
        logic clr [8];
        logic eov [8];
        int   eout[8];
        vin  = '{1, 1, 1, 1, 1, 1, 0, 0};
        err  = '{10, 10, 10, 10, 7, 10, 0, 0};
        kpv  = '{0, 0, 0, 0, 256, 0, 0, 0};
        clr  = '{0, 0, 0, 0, 0, 1, 0, 0};
        eov  = '{0, 1, 1, 1, 1, 1, 1, 0};
        eout = '{0, 5, 10, 15, 20, 7, 5, 5};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(1'b0, vin[c], err[c], kpv[c], 128, clr[c]);
            assertions += 2;
            if (out_valid !== eov[c]) begin
                failures++;
                $display("[TB] FAIL clear_ov c%0d: got %b expected %b", c, out_valid, eov[c]);
            end
            if (out !== 16'(eout[c])) begin
                failures++;
                $display("[TB] FAIL clear_out c%0d: got %0d expected %0d", c, out, eout[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic rin [12];
        logic vin [12];
        logic eov [12];
        int   eout[12];
        rin  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vin  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        eov  = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        eout = '{0, 5, 10, 15, 0, 0, 5, 10, 15, 20, 25, 25};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            apply_stimulus(rin[c], vin[c], 10, 0, 128, 1'b0);
            assertions += 2;
            if (out_valid !== eov[c]) begin
                failures++;
                $display("[TB] FAIL b2b_ov c%0d: got %b expected %b", c, out_valid, eov[c]);
            end
            if (out !== 16'(eout[c])) begin
                failures++;
                $display("[TB] FAIL b2b_out c%0d: got %0d expected %0d", c, out, eout[c]);
            end
        end
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        error      = '0;
        kp         = '0;
        ki         = '0;
        int_clear  = 1'b0;
        test_reset();
        test_proportional();
        test_integration();
        test_anti_windup();
        test_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
